pll_reset_seq: RTL and testbench

PLL lock supervisor and reset sequencer on the 27 MHz crystal domain. It drives the PLL's reset pin and qualifies the asynchronous `lock` output. It releases a synchronous active-high reset to the HDMI/video pipeline only after lock has been stable for a programmed time. On lock loss it re-asserts that reset immediately and, if lock does not return in time, pulses the PLL reset and retries.

---
 rtl/pll_reset_seq.sv | 121 ++++++++++++
 tb/tb_pll_reset_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL lock supervisor / reset sequencer on the clkin domain; outputs registered, change on the same edge as state.
// Optional macro PLL_RESET_SEQ_RETRY_EN enables PLL reset pulsing and timeout retries; no backpressure.
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELOCK_TIMEOUT     = 270000,
    parameter int CNT_W              = 20
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       rst_out,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] retry_cnt
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    if (PLL_RST_CYCLES < 2 || LOCK_STABLE_CYCLES < 2 || RELOCK_TIMEOUT < 1) begin : g_bad_cfg
        $error("pll_reset_seq: illegal cycle parameters");
    end

`ifdef PLL_RESET_SEQ_RETRY_EN
    localparam state_t RESET_STATE = S_PLL_RST;
`else
    localparam state_t RESET_STATE = S_WAIT_LOCK;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sync_q;
    logic               lock_s;
    logic               rst_out_q;
    logic               ready_q;

    assign lock_s = sync_q[1];

`ifdef PLL_RESET_SEQ_RETRY_EN
    logic [7:0] retry_q, retry_d;
    logic       pll_reset_q;
`endif

    always_comb begin
        state_d = state_q;
`ifdef PLL_RESET_SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
`ifdef PLL_RESET_SEQ_RETRY_EN
            S_PLL_RST: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
            end
            // Lock takes priority over a coincident timeout.
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CNT_W'(RELOCK_TIMEOUT - 1)) begin
                    state_d = S_PLL_RST;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end
            end
`else
            S_WAIT_LOCK: begin
                if (lock_s) state_d = S_STABLE;
            end
`endif
            S_STABLE: begin
                if (!lock_s) state_d = S_WAIT_LOCK;
                else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                if (!lock_s) state_d = S_WAIT_LOCK;
            end
            default: state_d = RESET_STATE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            sync_q    <= 2'b00;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
`ifdef PLL_RESET_SEQ_RETRY_EN
            retry_q     <= 8'd0;
            pll_reset_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= {sync_q[0], pll_lock};
            rst_out_q <= (state_d != S_RUN);
            ready_q   <= (state_d == S_RUN);
`ifdef PLL_RESET_SEQ_RETRY_EN
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == S_PLL_RST);
`endif
        end
    end

    assign state   = state_q;
    assign rst_out = rst_out_q;
    assign ready   = ready_q;
`ifdef PLL_RESET_SEQ_RETRY_EN
    assign pll_reset = pll_reset_q;
    assign retry_cnt = retry_q;
`else
    assign pll_reset = 1'b0;
    assign retry_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: phase/elapsed-time model checked every cycle plus literal milestones.
// Follows the PLL_RESET_SEQ_RETRY_EN setting of the build.
module tb_pll_reset_seq;

    localparam int PR = 4;
    localparam int LS = 8;
    localparam int RT = 32;
`ifdef PLL_RESET_SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif
    localparam int INIT_PH = RETRY ? 0 : 1;
    // lock_s needs two edges after reset, so without the PLL pulse STABLE starts at edge 3.
    localparam int T_RUN   = RETRY ? (PR + 1 + LS) : (3 + LS);

    logic       clkin;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic       rst_out;
    logic       ready;
    logic [1:0] state;
    logic [7:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    pll_reset_seq #(
        .PLL_RST_CYCLES    (PR),
        .LOCK_STABLE_CYCLES(LS),
        .RELOCK_TIMEOUT    (RT),
        .CNT_W             (8)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .rst_out  (rst_out),
        .ready    (ready),
        .state    (state),
        .retry_cnt(retry_cnt)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    // Model: phase number, edge of entry into the phase, and lock as seen two edges late.
    int cyc   = 0;
    int ph    = 0;
    int entry = 0;
    int rc    = 0;
    bit ls1   = 1'b0;
    bit ls2   = 1'b0;
    bit mvalid = 1'b0;

    always @(posedge clkin) begin
        int el;
        int nph;
        cyc++;
        if (reset) begin
            ph = INIT_PH; entry = cyc; rc = 0; ls1 = 1'b0; ls2 = 1'b0; mvalid = 1'b1;
        end else if (mvalid) begin
            el  = cyc - entry;
            nph = ph;
            if (ph == 0 && el == PR) nph = 1;
            else if (ph == 1 && ls2) nph = 2;
            else if (ph == 1 && RETRY && el == RT) begin
                nph = 0;
                rc  = (rc < 255) ? rc + 1 : 255;
            end
            else if ((ph == 2 || ph == 3) && !ls2) nph = 1;
            else if (ph == 2 && el == LS) nph = 3;
            if (nph != ph) begin
                ph = nph; entry = cyc;
            end
            ls2 = ls1;
            ls1 = pll_lock;
        end
    end

    always @(negedge clkin) begin
        logic [12:0] exp_v, act_v;
        if (mvalid) begin
            exp_v = {2'(ph), RETRY && (ph == 0), ph != 3, ph == 3, 8'(rc)};
            act_v = {state, pll_reset, rst_out, ready, retry_cnt};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle %0d outputs {state,pll_reset,rst_out,ready,retry}: got %b want %b",
                         cyc, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b1;
        step(3);
        chk("reset_state", int'(state), INIT_PH);
        chk("reset_pll_reset", int'(pll_reset), int'(RETRY));
        chk("reset_rst_out", int'(rst_out), 1);
        chk("reset_ready", int'(ready), 0);
        chk("reset_retry", int'(retry_cnt), 0);
        reset = 1'b0;

        // Clean start
        if (RETRY) begin
            step(PR - 1);
            chk("pll_reset_high_edge3", int'(pll_reset), 1);
            step(1);
            chk("pll_reset_low_edge4", int'(pll_reset), 0);
            step(1);
            chk("stable_edge5", int'(state), 2);
            step(T_RUN - 1 - (PR + 1));
        end else begin
            step(2);
            chk("wait_edge2", int'(state), 1);
            step(1);
            chk("stable_edge3", int'(state), 2);
            step(T_RUN - 1 - 3);
        end
        chk("rst_out_before_run", int'(rst_out), 1);
        step(1);
        chk("run_rst_out", int'(rst_out), 0);
        chk("run_ready", int'(ready), 1);
        chk("run_retry", int'(retry_cnt), 0);
        step(3);

        // Lock loss in RUN: one-cycle drop
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(2);
        chk("lockloss_rst_out", int'(rst_out), 1);
        chk("lockloss_state", int'(state), 1);
        step(8);
        chk("relock_not_yet", int'(ready), 0);
        step(1);
        chk("relock_ready", int'(ready), 1);
        step(4);

        // Glitch while STABLE at cnt=5
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(6);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(2);
        chk("glitch_state", int'(state), 1);
        chk("glitch_rst_out", int'(rst_out), 1);
        chk("glitch_retry", int'(retry_cnt), 0);
        step(8);
        chk("glitch_recount", int'(state), 2);
        step(1);
        chk("glitch_run", int'(ready), 1);

        // Never lock
        pll_lock = 1'b0;
        step(200);
        chk("nolock_retry_200", int'(retry_cnt), RETRY ? 5 : 0);
        if (!RETRY) chk("nolock_waiting", int'(state), 1);
        step(9200);
        chk("nolock_retry_sat", int'(retry_cnt), RETRY ? 255 : 0);
        pll_lock = 1'b1;
        step(60);
        chk("recover_ready", int'(ready), 1);

        // Reset in RUN, then during a PLL reset pulse
        reset = 1'b1;
        step(1);
        chk("rst_run_state", int'(state), INIT_PH);
        chk("rst_run_pll_reset", int'(pll_reset), int'(RETRY));
        chk("rst_run_rst_out", int'(rst_out), 1);
        chk("rst_run_retry", int'(retry_cnt), 0);
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        chk("rst_pulse_state", int'(state), INIT_PH);
        chk("rst_pulse_pll_reset", int'(pll_reset), int'(RETRY));
        chk("rst_pulse_rst_out", int'(rst_out), 1);
        reset = 1'b0;
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
